mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 89 ++++++++
 tb/tb_mem_arbiter.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - two-port (cpu/external) data-memory arbiter with round-robin and bounded ext lock
module mem_arbiter #(
  parameter int MAX_BURST = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic        cpu_byte,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  output logic        cpu_gnt,
  output logic        cpu_stall,
  output logic [31:0] cpu_rdata,
  output logic        cpu_rvalid,
  input  logic        ext_req,
  input  logic        ext_lock,
  input  logic        ext_we,
  input  logic        ext_byte,
  input  logic [31:0] ext_addr,
  input  logic [31:0] ext_wdata,
  output logic        ext_gnt,
  output logic [31:0] ext_rdata,
  output logic        ext_rvalid,
  output logic        mem_en,
  output logic        mem_we,
  output logic        mem_byte,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  localparam int CW = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
  localparam logic [CW-1:0] BURST_LAST = CW'(MAX_BURST - 1);

  logic          last_ext_q, last_ext_d;
  logic          lock_q, lock_d;
  logic [CW-1:0] burst_cnt_q, burst_cnt_d;
  logic          cpu_rv_q, cpu_rv_d;
  logic          ext_rv_q, ext_rv_d;

  // ext wins a tie when it holds a live lock or when cpu owned the last grant
  assign cpu_gnt   = cpu_req & ~(ext_req & (lock_q | ~last_ext_q));
  assign ext_gnt   = ext_req & ~cpu_gnt;
  assign cpu_stall = cpu_req & ~cpu_gnt;

  assign mem_en    = cpu_gnt | ext_gnt;
  assign mem_we    = (cpu_gnt & cpu_we) | (ext_gnt & ext_we);
  assign mem_byte  = (cpu_gnt & cpu_byte) | (ext_gnt & ext_byte);
  assign mem_addr  = ({32{cpu_gnt}} & cpu_addr) | ({32{ext_gnt}} & ext_addr);
  assign mem_wdata = ({32{cpu_gnt}} & cpu_wdata) | ({32{ext_gnt}} & ext_wdata);

  assign cpu_rdata  = mem_rdata;
  assign ext_rdata  = mem_rdata;
  assign cpu_rvalid = cpu_rv_q;
  assign ext_rvalid = ext_rv_q;

  always_comb begin
    last_ext_d  = last_ext_q;
    burst_cnt_d = '0;
    lock_d      = 1'b0;
    if (ext_gnt) last_ext_d = 1'b1;
    else if (cpu_gnt) last_ext_d = 1'b0;
    // counter saturates so a long ext-only stretch keeps the lock ignored
    if (ext_gnt && ext_lock) begin
      lock_d      = (burst_cnt_q < BURST_LAST);
      burst_cnt_d = (burst_cnt_q == BURST_LAST) ? burst_cnt_q : burst_cnt_q + CW'(1);
    end
    cpu_rv_d = cpu_gnt & ~cpu_we;
    ext_rv_d = ext_gnt & ~ext_we;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      last_ext_q  <= 1'b1;
      lock_q      <= 1'b0;
      burst_cnt_q <= '0;
      cpu_rv_q    <= 1'b0;
      ext_rv_q    <= 1'b0;
    end else begin
      last_ext_q  <= last_ext_d;
      lock_q      <= lock_d;
      burst_cnt_q <= burst_cnt_d;
      cpu_rv_q    <= cpu_rv_d;
      ext_rv_q    <= ext_rv_d;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - vector table, corner sequences and random model check for mem_arbiter
module tb_mem_arbiter;
  localparam int MAXB = 8;

  logic        clk = 1'b0;
  logic        reset;
  logic        cpu_req, cpu_we, cpu_byte;
  logic [31:0] cpu_addr, cpu_wdata;
  logic        cpu_gnt, cpu_stall, cpu_rvalid;
  logic [31:0] cpu_rdata;
  logic        ext_req, ext_lock, ext_we, ext_byte;
  logic [31:0] ext_addr, ext_wdata;
  logic        ext_gnt, ext_rvalid;
  logic [31:0] ext_rdata;
  logic        mem_en, mem_we, mem_byte;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  mem_arbiter #(.MAX_BURST(MAXB)) dut (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_byte(cpu_byte),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_gnt(cpu_gnt), .cpu_stall(cpu_stall), .cpu_rdata(cpu_rdata), .cpu_rvalid(cpu_rvalid),
    .ext_req(ext_req), .ext_lock(ext_lock), .ext_we(ext_we), .ext_byte(ext_byte),
    .ext_addr(ext_addr), .ext_wdata(ext_wdata),
    .ext_gnt(ext_gnt), .ext_rdata(ext_rdata), .ext_rvalid(ext_rvalid),
    .mem_en(mem_en), .mem_we(mem_we), .mem_byte(mem_byte),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  typedef struct {
    logic        cr, cw, cb;
    logic [31:0] ca, cd;
    logic        er, el, ew, eb;
    logic [31:0] ea, ed;
    logic        xcg, xeg, xwe, xbyte;
    logic [31:0] xaddr, xwdata;
    logic        xcrv, xerv;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic idle_in();
    cpu_req = 0; cpu_we = 0; cpu_byte = 0; cpu_addr = 0; cpu_wdata = 0;
    ext_req = 0; ext_lock = 0; ext_we = 0; ext_byte = 0; ext_addr = 0; ext_wdata = 0;
  endtask

  task automatic set_in(input vec_t v);
    cpu_req = v.cr; cpu_we = v.cw; cpu_byte = v.cb; cpu_addr = v.ca; cpu_wdata = v.cd;
    ext_req = v.er; ext_lock = v.el; ext_we = v.ew; ext_byte = v.eb; ext_addr = v.ea; ext_wdata = v.ed;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int m_run, m_pend, g;
    logic m_last_ext, prio, gwe;
    logic [31:0] xa, xd;
    logic xb;

    vecs[0] = '{1,0,0,32'h100,32'h11, 1,0,0,0,32'h200,32'h22, 1,0,0,0,32'h100,32'h11, 0,0};
    vecs[1] = '{1,0,0,32'h104,32'h11, 1,0,0,0,32'h204,32'h22, 0,1,0,0,32'h204,32'h22, 1,0};
    vecs[2] = '{1,0,0,32'h108,32'h11, 1,0,0,0,32'h208,32'h22, 1,0,0,0,32'h108,32'h11, 0,1};
    vecs[3] = '{1,1,1,32'h40,32'hDEADBEEF, 0,0,0,0,32'h20C,32'h22, 1,0,1,1,32'h40,32'hDEADBEEF, 1,0};
    vecs[4] = '{0,0,0,32'h50,32'h77, 0,0,0,0,32'h60,32'h88, 0,0,0,0,32'h0,32'h0, 0,0};
    vecs[5] = '{0,0,0,32'h50,32'h77, 1,0,1,1,32'h300,32'h33, 0,1,1,1,32'h300,32'h33, 0,0};
    vecs[6] = '{0,0,0,32'h50,32'h77, 1,1,0,0,32'h304,32'h44, 0,1,0,0,32'h304,32'h44, 0,0};
    vecs[7] = '{1,0,0,32'h10C,32'h55, 1,0,0,0,32'h308,32'h66, 0,1,0,0,32'h308,32'h66, 0,1};
    vecs[8] = '{1,0,0,32'h110,32'h55, 1,0,0,0,32'h30C,32'h66, 1,0,0,0,32'h110,32'h55, 0,1};
    vecs[9] = '{0,0,0,32'h0,32'h0, 0,0,0,0,32'h0,32'h0, 0,0,0,0,32'h0,32'h0, 1,0};

    // reset state: arbitration stays live, tie goes to cpu, no rvalid
    reset = 0; mem_rdata = 32'h0;
    idle_in();
    cpu_req = 1; ext_req = 1; cpu_addr = 32'hA0; ext_addr = 32'hB0;
    @(negedge clk);
    chk("rst_cpu_gnt", cpu_gnt, 1);
    chk("rst_ext_gnt", ext_gnt, 0);
    chk("rst_mem_en", mem_en, 1);
    chk("rst_mem_addr", mem_addr, 32'hA0);
    chk("rst_rvalids", {cpu_rvalid, ext_rvalid}, 0);
    next_cycle();
    chk("rst_rvalids_hold", {cpu_rvalid, ext_rvalid}, 0);
    @(negedge clk);
    idle_in(); reset = 1;
    next_cycle();

    for (int i = 0; i < 10; i++) begin
      set_in(vecs[i]);
      mem_rdata = 32'h1000 + i;
      @(negedge clk);
      chk($sformatf("vec%0d_cpu_gnt", i), cpu_gnt, vecs[i].xcg);
      chk($sformatf("vec%0d_ext_gnt", i), ext_gnt, vecs[i].xeg);
      chk($sformatf("vec%0d_mem_en", i), mem_en, vecs[i].xcg | vecs[i].xeg);
      chk($sformatf("vec%0d_mem_we", i), mem_we, vecs[i].xwe);
      chk($sformatf("vec%0d_mem_byte", i), mem_byte, vecs[i].xbyte);
      chk($sformatf("vec%0d_mem_addr", i), mem_addr, vecs[i].xaddr);
      chk($sformatf("vec%0d_mem_wdata", i), mem_wdata, vecs[i].xwdata);
      chk($sformatf("vec%0d_stall", i), cpu_stall, vecs[i].cr & ~vecs[i].xcg);
      chk($sformatf("vec%0d_cpu_rvalid", i), cpu_rvalid, vecs[i].xcrv);
      chk($sformatf("vec%0d_ext_rvalid", i), ext_rvalid, vecs[i].xerv);
      next_cycle();
    end

    // locked burst: cpu owns last grant, then ext holds for MAXB cycles
    idle_in(); cpu_req = 1;
    @(negedge clk); chk("pre_burst_cpu", cpu_gnt, 1);
    next_cycle();
    cpu_req = 1; ext_req = 1; ext_lock = 1;
    for (int c = 0; c <= MAXB; c++) begin
      @(negedge clk);
      chk($sformatf("burst%0d_ext_gnt", c), ext_gnt, (c < MAXB));
      chk($sformatf("burst%0d_cpu_gnt", c), cpu_gnt, (c >= MAXB));
      chk($sformatf("burst%0d_stall", c), cpu_stall, (c < MAXB));
      next_cycle();
    end
    idle_in(); next_cycle();

    // lock released by ext dropping req, then a fresh full burst proves the count restarted
    cpu_req = 1; ext_req = 1; ext_lock = 1;
    for (int c = 0; c <= 12; c++) begin
      ext_req = (c != 3);
      @(negedge clk);
      chk($sformatf("drop%0d_cpu_gnt", c), cpu_gnt, (c == 3 || c == 12));
      chk($sformatf("drop%0d_ext_gnt", c), ext_gnt, !(c == 3 || c == 12));
      next_cycle();
    end
    idle_in(); next_cycle();

    // idle stretch leaves last_owner (cpu) untouched
    for (int c = 0; c < 5; c++) begin
      cpu_addr = 32'h5555; ext_addr = 32'h6666;
      @(negedge clk);
      chk($sformatf("idle%0d_mem_en", c), mem_en, 0);
      chk($sformatf("idle%0d_mem_addr", c), mem_addr, 0);
      chk($sformatf("idle%0d_rvalids", c), {cpu_rvalid, ext_rvalid}, 0);
      next_cycle();
    end
    cpu_req = 1; ext_req = 1;
    @(negedge clk); chk("post_idle_ext_gnt", ext_gnt, 1);
    next_cycle();
    idle_in(); next_cycle();

    // reset with an ext read in flight
    ext_req = 1;
    @(negedge clk); chk("inflight_ext_gnt", ext_gnt, 1);
    reset = 0;
    cpu_req = 1;
    #1;
    chk("inflight_rst_cpu_gnt", cpu_gnt, 1);
    chk("inflight_rst_mem_en", mem_en, 1);
    next_cycle();
    chk("inflight_rst_ext_rvalid", ext_rvalid, 0);
    chk("inflight_rst_cpu_rvalid", cpu_rvalid, 0);
    @(negedge clk); idle_in(); reset = 1;
    next_cycle();
    chk("inflight_rel_rvalids", {cpu_rvalid, ext_rvalid}, 0);
    cpu_req = 1; ext_req = 1;
    @(negedge clk); chk("inflight_first_tie", cpu_gnt, 1);
    next_cycle();

    // randomized run against a rule-level model
    idle_in(); reset = 0; next_cycle();
    @(negedge clk); reset = 1; next_cycle();
    m_last_ext = 1; m_run = 0; m_pend = -1;
    for (int i = 0; i < 1500; i++) begin
      cpu_req = ($urandom_range(0, 1) == 1); cpu_we = ($urandom_range(0, 2) == 0);
      cpu_byte = $urandom_range(0, 1); cpu_addr = $urandom; cpu_wdata = $urandom;
      ext_req = ($urandom_range(0, 3) != 0); ext_lock = ($urandom_range(0, 5) != 0);
      ext_we = ($urandom_range(0, 2) == 0); ext_byte = $urandom_range(0, 1);
      ext_addr = $urandom; ext_wdata = $urandom; mem_rdata = $urandom;
      prio = ext_req && m_run > 0 && m_run < MAXB;
      if (prio) g = 1;
      else if (cpu_req && ext_req) g = m_last_ext ? 0 : 1;
      else if (cpu_req) g = 0;
      else if (ext_req) g = 1;
      else g = -1;
      xa = (g == 0) ? cpu_addr : (g == 1) ? ext_addr : 32'h0;
      xd = (g == 0) ? cpu_wdata : (g == 1) ? ext_wdata : 32'h0;
      xb = (g == 0) ? cpu_byte : (g == 1) ? ext_byte : 1'b0;
      gwe = (g == 0) ? cpu_we : (g == 1) ? ext_we : 1'b0;
      @(negedge clk);
      chk("rnd_cpu_gnt", cpu_gnt, (g == 0));
      chk("rnd_ext_gnt", ext_gnt, (g == 1));
      chk("rnd_mem_en", mem_en, (g >= 0));
      chk("rnd_mem_we", mem_we, gwe);
      chk("rnd_mem_byte", mem_byte, xb);
      chk("rnd_mem_addr", mem_addr, xa);
      chk("rnd_mem_wdata", mem_wdata, xd);
      chk("rnd_stall", cpu_stall, cpu_req && g != 0);
      chk("rnd_cpu_rvalid", cpu_rvalid, (m_pend == 0));
      chk("rnd_ext_rvalid", ext_rvalid, (m_pend == 1));
      chk("rnd_cpu_rdata", cpu_rdata, mem_rdata);
      chk("rnd_ext_rdata", ext_rdata, mem_rdata);
      if (g == 1 && ext_lock) m_run++;
      else m_run = 0;
      if (g >= 0) m_last_ext = (g == 1);
      m_pend = (g >= 0 && !gwe) ? g : -1;
      next_cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
